// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch/exception redirect controller.
// Holds the FSM state, redirect source and address types used by the top and its counter.
package branch_redirect_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DS,
        REDIRECT
    } redirect_state_t;

    typedef enum logic {
        SRC_BRANCH,
        SRC_EXC
    } redirect_src_t;

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Free-running event counter with increment enable.
// Wraps naturally at its width.
module perf_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a mispredicted branch (after its delay slot) or a commit-stage exception into a
// single registered redirect request to fetch, and counts completed branch redirects.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             bru_valid,
    input  logic             bru_fail,
    input  logic             bru_adel,
    input  addr_t            bru_recover_pc,
    input  logic             ds_issued,
    input  logic             exc_valid,
    input  addr_t            exc_pc,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output addr_t            redirect_pc,
    output logic             flush_front,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_cnt
);

    redirect_state_t r_state;
    redirect_state_t w_stateNext;
    redirect_src_t   r_src;
    redirect_src_t   w_srcNext;
    addr_t           r_target;
    addr_t           w_targetNext;

    logic            r_redirectValid;
    logic            r_flushFront;
    logic            r_busy;
    addr_t           r_redirectPc;

    logic            w_branchAccept;
    logic            w_countInc;

    assign w_branchAccept = bru_valid & bru_fail & ~bru_adel;

    // An exception arriving on the handshake cycle replaces the branch redirect, so it is not counted.
    assign w_countInc = r_redirectValid & fetch_ready & ~exc_valid & (r_src == SRC_BRANCH);

    always_comb begin
        w_stateNext  = r_state;
        w_srcNext    = r_src;
        w_targetNext = r_target;
        if (exc_valid) begin
            w_stateNext  = REDIRECT;
            w_srcNext    = SRC_EXC;
            w_targetNext = exc_pc;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_branchAccept) begin
                        w_srcNext    = SRC_BRANCH;
                        w_targetNext = bru_recover_pc;
                        w_stateNext  = ds_issued ? REDIRECT : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    if (ds_issued) begin
                        w_stateNext = REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (fetch_ready) begin
                        w_stateNext = IDLE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_src    <= SRC_BRANCH;
            r_target <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_src    <= w_srcNext;
            r_target <= w_targetNext;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirectValid <= 1'b0;
            r_flushFront    <= 1'b0;
            r_busy          <= 1'b0;
            r_redirectPc    <= '0;
        end else begin
            r_redirectValid <= (w_stateNext == REDIRECT);
            r_flushFront    <= (w_stateNext == REDIRECT);
            r_busy          <= (w_stateNext != IDLE);
            if (w_stateNext == REDIRECT) begin
                r_redirectPc <= w_targetNext;
            end
        end
    end

    perf_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_countInc),
        .o_count (mispredict_cnt)
    );

    assign redirect_valid = r_redirectValid;
    assign redirect_pc    = r_redirectPc;
    assign flush_front    = r_flushFront;
    assign busy           = r_busy;

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-002 The module SHALL have input bru_valid  in  1  branch resolved in exec this cycle.
REQ-003 The module SHALL have input bru_fail  in  1  resolved branch mispredicted (direction or target).
REQ-004 The module SHALL have input bru_adel  in  1  branch target/link address misaligned; branch is not redirected.
REQ-005 The module SHALL have input bru_recover_pc  in  32  correct next-fetch PC after the delay slot.
REQ-006 The module SHALL have input ds_issued  in  1  delay-slot instruction of the resolving branch has entered exec.
REQ-007 The module SHALL have inputs exc_valid  in  1  and exc_pc  in  32: commit-stage exception/ERET redirect request and its vector.
REQ-008 The module SHALL have input fetch_ready  in  1  fetch accepts a redirect this cycle.
REQ-009 The module SHALL have outputs redirect_valid  out  1 and redirect_pc  out  32: redirect request to fetch.
REQ-010 The module SHALL have output flush_front  out  1  kill IF/ID instructions younger than the delay slot.
REQ-011 The module SHALL have output busy  out  1  issue must not send another branch to exec.
REQ-012 The module SHALL have output mispredict_cnt  out  16  count of completed branch redirects.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT_DS, REDIRECT.
REQ-014 Branch accept: in IDLE with bru_valid & bru_fail & ~bru_adel & ~exc_valid, the module SHALL latch bru_recover_pc, mark the source as branch, and go to REDIRECT if ds_issued is high that cycle, otherwise to WAIT_DS.
REQ-015 In WAIT_DS the module SHALL go to REDIRECT on the first cycle ds_issued=1, keeping the latched PC.
REQ-016 In REDIRECT, redirect_valid=1 and flush_front=1 SHALL be held until the cycle fetch_ready=1, after which the next state is IDLE.
REQ-017 All outputs SHALL be registered; redirect_valid rises in the cycle after the transition into REDIRECT (an accept with ds_issued in cycle N gives redirect_valid at N+1).
REQ-018 busy SHALL be 1 in WAIT_DS and REDIRECT and 0 in IDLE.
REQ-019 In busy states, bru_valid SHALL be ignored.
REQ-020 exc_valid SHALL have priority in every state: the module latches exc_pc, marks the source as exception, and goes to REDIRECT, discarding any pending branch redirect.
REQ-021 In REDIRECT, exc_valid coinciding with fetch_ready SHALL start a new REDIRECT cycle with exc_pc; the completing branch redirect is not counted.
REQ-022 exc_valid and a branch accept in the same IDLE cycle SHALL resolve to exception; the branch is dropped.
REQ-023 bru_valid with bru_fail=0, or with bru_adel=1, SHALL cause no state change.
REQ-024 mispredict_cnt SHALL increment by 1 on each REDIRECT handshake (redirect_valid & fetch_ready) whose source is branch, and wrap from 16'hFFFF to 0.
REQ-025 redirect_pc SHALL hold its last value while redirect_valid=0.

Reset
REQ-026 While resetn=0 the module SHALL hold: state=IDLE, redirect_valid=0, redirect_pc=32'h0, flush_front=0, busy=0, mispredict_cnt=0, source=branch.
REQ-027 Reset asserted mid-WAIT_DS or mid-REDIRECT SHALL abandon the pending redirect; no redirect is issued after reset deasserts.

Structure
REQ-028 The shared package SHALL hold the redirect_state_t enum (IDLE, WAIT_DS, REDIRECT), the redirect_src_t enum (SRC_BRANCH, SRC_EXC), and reuse the existing addr_t.
REQ-029 The counter SHALL be a sub-module, perf_counter, with a width parameter, inc and async active-low reset; the FSM stays in branch_redirect_ctrl.

Verification
REQ-030 The bench SHALL cover: bru_valid=1, bru_fail=1, ds_issued=1, pc=32'hBFC0_0100, fetch_ready=1 -> redirect_valid=1 and pc=32'hBFC0_0100 for exactly one cycle at N+1, then mispredict_cnt=1.
REQ-031 The bench SHALL cover: a fail with ds_issued delayed by 3 cycles -> WAIT_DS for 3 cycles with busy=1 and redirect_valid=0, then redirect at the cycle after ds_issued.
REQ-032 The bench SHALL cover: REDIRECT with fetch_ready low for 4 cycles -> redirect_valid, flush_front and redirect_pc held stable for 4 cycles, released 1 cycle after fetch_ready.
REQ-033 The bench SHALL cover: exc_valid with exc_pc=32'hBFC0_0380 during WAIT_DS -> redirect to 32'hBFC0_0380 and mispredict_cnt unchanged.
REQ-034 The bench SHALL cover: bru_fail=1 with bru_adel=1, and separately bru_fail=1 with exc_valid in the same cycle -> no branch redirect in either case (the exception redirect only in the second case).
REQ-035 The bench SHALL cover: preloading the counter to 16'hFFFF and completing one branch redirect -> mispredict_cnt=0; resetn pulsed low during REDIRECT -> all outputs 0 immediately.
